seven_segment_frame_reader: RTL and testbench

// Receive-side counterpart of seven_segment_decoder: watches a time-multiplexed
// 7-segment bus (segment lines + one-hot digit select) and recovers the digits.

---
 rtl/seven_segment_frame_reader.sv | 123 ++++++++++++
 tb/tb_seven_segment_frame_reader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seven_segment_frame_reader.sv
// seven_segment_frame_reader: recovers debounced digit frames from a multiplexed 7-segment bus
module seven_segment_frame_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic                    err_pulse,
    output logic                    overrun
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = 7 + NUM_DIGITS;
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

    typedef enum logic {COLLECT, PRESENT} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           s1_q, s1_d, prev_q, prev_d, acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    accept_q, accept_d;
    logic [4*NUM_DIGITS-1:0] slots_q, slots_d, digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_next, acc_dig;
    logic [6:0]              acc_seg;
    logic [3:0]              code;
    logic                    err_q, err_d, ovr_q, ovr_d;
    logic                    one_hot, store, done;

    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'b0111111: return 4'h0;
            7'b0000110: return 4'h1;
            7'b1011011: return 4'h2;
            7'b1001111: return 4'h3;
            7'b1100110: return 4'h4;
            7'b1101101: return 4'h5;
            7'b1111101: return 4'h6;
            7'b0000111: return 4'h7;
            7'b1111111: return 4'h8;
            7'b1101111: return 4'h9;
            7'b0000000: return 4'hF;
            default:    return 4'hE;
        endcase
    endfunction

    // Sampling and debounce: a run is accepted exactly once, when its count first reaches the limit
    always_comb begin
        s1_d     = {seg_in, dig_sel};
        prev_d   = s1_q;
        cnt_d    = (s1_q != prev_q) ? CW'(1) : (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
        accept_d = (cnt_d == CMAX) && (cnt_q != CMAX || s1_q != prev_q);
        acc_d    = accept_d ? s1_q : acc_q;
    end

    // Decode the accepted sample into slots and flag bad patterns or bad selects
    always_comb begin
        acc_seg   = acc_q[SW-1:NUM_DIGITS];
        acc_dig   = acc_q[NUM_DIGITS-1:0];
        code      = decode(acc_seg);
        one_hot   = (acc_dig != '0) && ((acc_dig & (acc_dig - 1'b1)) == '0);
        store     = accept_q && one_hot;
        slots_d   = slots_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            slots_d[4*i +: 4] = (store && acc_dig[i]) ? code : slots_q[4*i +: 4];
        seen_next = store ? (seen_q | acc_dig) : seen_q;
        done      = &seen_next;
        err_d     = (accept_q && acc_dig != '0 && !one_hot) || (store && code == 4'hE);
    end

    // Frame hand-off: load on completion, drop with overrun if the held frame is not yet taken
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        seen_d   = done ? '0 : seen_next;
        ovr_d    = 1'b0;
        if (done) begin
            if (state_q == COLLECT || out_ready) begin
                digits_d = slots_d;
                state_d  = PRESENT;
            end else
                ovr_d = 1'b1;
        end else if (state_q == PRESENT && out_ready)
            state_d = COLLECT;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLLECT;
            s1_q     <= '0;
            prev_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            slots_q  <= '0;
            digits_q <= '0;
            seen_q   <= '0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
            slots_q  <= slots_d;
            digits_q <= digits_d;
            seen_q   <= seen_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    assign out_valid  = (state_q == PRESENT);
    assign digits_out = digits_q;
    assign err_pulse  = err_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_seven_segment_frame_reader.sv
// tb_seven_segment_frame_reader: directed scoreboard bench for the 7-segment frame reader
module tb_seven_segment_frame_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] digits_out;
    logic        err_pulse;
    logic        overrun;

    int pass_cnt = 0;
    int total_cnt = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    int valid_cnt = 0;
    logic [15:0] exp_q[$];

    seven_segment_frame_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel), .out_ready(out_ready),
        .out_valid(out_valid), .digits_out(digits_out), .err_pulse(err_pulse), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    task automatic show(input logic [6:0] s, input logic [3:0] d, input int n);
        seg_in  = s;
        dig_sel = d;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input int pos, input int d);
        show(seg(d), 4'(1 << pos), 5);
    endtask

    task automatic idle(input int n);
        show(7'b0, 4'b0, n);
    endtask

    // Monitor: count pulses and score every accepted frame against the expected queue
    always @(negedge clk) begin
        if (!rst) begin
            err_cnt   += int'(err_pulse);
            ovr_cnt   += int'(overrun);
            valid_cnt += int'(out_valid);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_frame", 32'(digits_out), 32'hDEAD);
                else
                    check("frame", 32'(digits_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_valid", 32'(out_valid), 0);
        check("rst_digits", 32'(digits_out), 0);
        check("rst_err", 32'(err_pulse), 0);
        check("rst_ovr", 32'(overrun), 0);
        rst = 1'b0;
        out_ready = 1'b1;

        exp_q.push_back(16'h1234);
        put(3, 1); put(2, 2); put(1, 3); put(0, 4);
        idle(10);
        check("valid_one_cycle", 32'(valid_cnt), 1);
        check("q_empty_1", 32'(exp_q.size()), 0);

        exp_q.push_back(16'h5670);
        show(seg(0), 4'b0001, 5);
        show(seg(8), 4'b0001, 2);
        show(seg(0), 4'b0001, 5);
        put(1, 7); put(2, 6); put(3, 5);
        idle(10);
        check("glitch_err", 32'(err_cnt), 0);
        check("q_empty_2", 32'(exp_q.size()), 0);

        exp_q.push_back(16'h3E89);
        show(7'b1110001, 4'b0100, 5);
        idle(6);
        check("bad_pattern_err", 32'(err_cnt), 1);
        show(seg(1), 4'b0110, 5);
        idle(6);
        check("bad_sel_err", 32'(err_cnt), 2);
        put(3, 3); put(1, 8); put(0, 9);
        idle(10);
        check("q_empty_3", 32'(exp_q.size()), 0);

        out_ready = 1'b0;
        exp_q.push_back(16'h4321);
        put(0, 1); put(1, 2); put(2, 3); put(3, 4);
        put(0, 5); put(1, 6); put(2, 7); put(3, 8);
        idle(10);
        check("overrun_once", 32'(ovr_cnt), 1);
        check("held_valid", 32'(out_valid), 1);
        check("held_digits", 32'(digits_out), 32'h4321);
        out_ready = 1'b1;
        idle(4);
        check("q_empty_4", 32'(exp_q.size()), 0);
        check("consumed_valid", 32'(out_valid), 0);

        put(2, 9); put(3, 9);
        seg_in = '0;
        dig_sel = '0;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_digits", 32'(digits_out), 0);
        exp_q.push_back(16'h5102);
        put(0, 2); put(1, 0); put(2, 1); put(3, 5);
        idle(10);
        check("q_empty_5", 32'(exp_q.size()), 0);
        check("err_total", 32'(err_cnt), 2);
        check("ovr_total", 32'(ovr_cnt), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
